// File: rtl/ysyx_201979054_div_pkg.sv
// Shared definitions for the iterative divider: ALU control codes, FSM states and op-class helpers.
package ysyx_201979054_div_pkg;

  localparam logic [4:0] ALU_DIVU  = 5'b10101;
  localparam logic [4:0] ALU_REMU  = 5'b10111;
  localparam logic [4:0] ALU_DIVW  = 5'b10011;
  localparam logic [4:0] ALU_REMW  = 5'b11001;
  localparam logic [4:0] ALU_DIVUW = 5'b10110;
  localparam logic [4:0] ALU_REMUW = 5'b11000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] code);
    case (code)
      ALU_DIVU, ALU_REMU, ALU_DIVW, ALU_REMW, ALU_DIVUW, ALU_REMUW: is_div_op = 1'b1;
      default: is_div_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_w_op(input logic [4:0] code);
    case (code)
      ALU_DIVW, ALU_REMW, ALU_DIVUW, ALU_REMUW: is_w_op = 1'b1;
      default: is_w_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_rem_op(input logic [4:0] code);
    case (code)
      ALU_REMU, ALU_REMW, ALU_REMUW: is_rem_op = 1'b1;
      default: is_rem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [4:0] code);
    case (code)
      ALU_DIVW, ALU_REMW: is_signed_op = 1'b1;
      default: is_signed_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_201979054_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module ysyx_201979054_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            bit_in,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // rem_in < divisor always holds, so the extra top bit of diff_s is a clean borrow flag
  always_comb begin
    shifted_s = {rem_in, bit_in};
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[XLEN]) begin
      rem_out = shifted_s[XLEN-1:0];
      q_bit   = 1'b0;
    end else begin
      rem_out = diff_s[XLEN-1:0];
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_201979054_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIVU/REMU/DIVW/REMW/DIVUW/REMUW.
// Optional early-out for |dividend| < |divisor| is enabled by defining DIV_EARLY_OUT_EN.
module ysyx_201979054_div_unit
  import ysyx_201979054_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [4:0]      i_alu_control,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal_op
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e      state_r, state_s;
  logic [XLEN-1:0] rem_r, quo_r, dvs_r, result_r;
  logic [CNT_W-1:0] cnt_r;
  logic            w_r, rem_op_r, neg_q_r, neg_r_r;
  logic            busy_r, done_r, illegal_r;

  logic            op_w_s, op_sgn_s, op_rem_s, a_neg_s, b_neg_s;
  logic            div_zero_s, ovf_s, early_s, accept_s, illegal_s;
  logic [31:0]     a_lo_s, b_lo_s, a_mag32_s, b_mag32_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, dvd_ext_s, spec_res_s;
  logic [XLEN-1:0] q_fix_s, r_fix_s, sel_s, fix_res_s, rem_nx_s;
  logic            q_bit_s;

  ysyx_201979054_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_r),
    .divisor (dvs_r),
    .bit_in  (quo_r[XLEN-1]),
    .rem_out (rem_nx_s),
    .q_bit   (q_bit_s)
  );

  // Operand decode for the accept cycle, and sign fix-up of the finished quotient/remainder
  always_comb begin
    op_w_s    = is_w_op(i_alu_control);
    op_sgn_s  = is_signed_op(i_alu_control);
    op_rem_s  = is_rem_op(i_alu_control);
    a_lo_s    = i_dividend[31:0];
    b_lo_s    = i_divisor[31:0];
    a_neg_s   = op_sgn_s & a_lo_s[31];
    b_neg_s   = op_sgn_s & b_lo_s[31];
    a_mag32_s = a_neg_s ? (32'd0 - a_lo_s) : a_lo_s;
    b_mag32_s = b_neg_s ? (32'd0 - b_lo_s) : b_lo_s;
    if (op_w_s) begin
      mag_a_s   = {{(XLEN-32){1'b0}}, a_mag32_s};
      mag_b_s   = {{(XLEN-32){1'b0}}, b_mag32_s};
      dvd_ext_s = {{(XLEN-32){a_lo_s[31]}}, a_lo_s};
    end else begin
      mag_a_s   = i_dividend;
      mag_b_s   = i_divisor;
      dvd_ext_s = i_dividend;
    end
    div_zero_s = (mag_b_s == {XLEN{1'b0}});
    ovf_s      = (i_alu_control == ALU_DIVW) && (a_lo_s == 32'h8000_0000)
                 && (b_lo_s == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    early_s    = !div_zero_s && (mag_a_s < mag_b_s);
`else
    early_s    = 1'b0;
`endif
    if (div_zero_s) begin
      spec_res_s = op_rem_s ? dvd_ext_s : {XLEN{1'b1}};
    end else if (ovf_s) begin
      spec_res_s = {{(XLEN-32){1'b1}}, 32'h8000_0000};
    end else begin
      spec_res_s = op_rem_s ? dvd_ext_s : {XLEN{1'b0}};
    end
    q_fix_s = neg_q_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
    r_fix_s = neg_r_r ? ({XLEN{1'b0}} - rem_r) : rem_r;
    sel_s   = rem_op_r ? r_fix_s : q_fix_s;
    if (w_r) begin
      fix_res_s = {{(XLEN-32){sel_s[31]}}, sel_s[31:0]};
    end else begin
      fix_res_s = sel_s;
    end
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    illegal_s = 1'b0;
    if (i_flush) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_start && is_div_op(i_alu_control)) begin
            accept_s = 1'b1;
            state_s  = (div_zero_s || ovf_s || early_s) ? S_DONE : S_CALC;
          end else if (i_start) begin
            illegal_s = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_CALC:  state_s = (cnt_r == {CNT_W{1'b0}}) ? S_FIX : S_CALC;
        S_FIX:   state_s = S_DONE;
        S_DONE:  state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State, registered outputs and the iterative datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= S_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      result_r  <= {XLEN{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      quo_r     <= {XLEN{1'b0}};
      dvs_r     <= {XLEN{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      w_r       <= 1'b0;
      rem_op_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s == S_CALC) || (state_s == S_FIX);
      done_r    <= (state_s == S_DONE);
      illegal_r <= illegal_s;
      if (state_s == S_DONE) begin
        result_r <= (state_r == S_FIX) ? fix_res_s : spec_res_s;
      end
      if (accept_s) begin
        w_r      <= op_w_s;
        rem_op_r <= op_rem_s;
        neg_q_r  <= a_neg_s ^ b_neg_s;
        neg_r_r  <= a_neg_s;
        rem_r    <= {XLEN{1'b0}};
        // W dividends are left-aligned so 32 shifts leave the quotient in the low half
        quo_r    <= op_w_s ? {a_mag32_s, {(XLEN-32){1'b0}}} : mag_a_s;
        dvs_r    <= mag_b_s;
        cnt_r    <= op_w_s ? CNT_W'(32 - 1) : CNT_W'(XLEN - 1);
      end else if (state_r == S_CALC) begin
        rem_r <= rem_nx_s;
        quo_r <= {quo_r[XLEN-2:0], q_bit_s};
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_result     = result_r;
  assign o_illegal_op = illegal_r;

endmodule

// File: tb/tb_ysyx_201979054_div_unit.sv
// Scoreboard bench for the divider: expected results and latencies are queued at issue and checked on o_done.
module tb_ysyx_201979054_div_unit;

  localparam logic [4:0] C_DIVU  = 5'b10101;
  localparam logic [4:0] C_REMU  = 5'b10111;
  localparam logic [4:0] C_DIVW  = 5'b10011;
  localparam logic [4:0] C_REMW  = 5'b11001;
  localparam logic [4:0] C_DIVUW = 5'b10110;
  localparam logic [4:0] C_REMUW = 5'b11000;

  typedef struct {
    string       tag;
    logic [63:0] exp;
    int          lat;
    int          acc;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  ctrl = 5'd0;
  logic [63:0] dvd = 64'd0;
  logic [63:0] dvs = 64'd0;
  logic        flush = 1'b0;
  logic        busy, done, illegal;
  logic [63:0] result;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  sb_item_t    sb[$];
  sb_item_t    mon_it;

  ysyx_201979054_div_unit #(.XLEN(64)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_alu_control (ctrl),
    .i_dividend    (dvd),
    .i_divisor     (dvs),
    .i_flush       (flush),
    .o_busy        (busy),
    .o_done        (done),
    .o_result      (result),
    .o_illegal_op  (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() > 0) begin
        mon_it = sb.pop_front();
        check({mon_it.tag, "_res"}, result, mon_it.exp);
        check({mon_it.tag, "_lat"}, 64'(cyc - mon_it.acc), 64'(mon_it.lat));
      end
    end
  end

  task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
    sb_item_t it;
    @(posedge clk); #1;
    it.tag = tag; it.exp = exp; it.lat = lat; it.acc = cyc;
    sb.push_back(it);
    start = 1'b1; ctrl = op; dvd = a; dvs = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, (lat > 1) ? 64'd1 : 64'd0);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check({tag, "_pending"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic launch(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    start = 1'b1; ctrl = op; dvd = a; dvs = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  int          done_base;
  logic [63:0] prev_res;
  int          early_lat;

  initial begin
`ifdef DIV_EARLY_OUT_EN
    early_lat = 1;
`else
    early_lat = 66;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);
    check("rst_result", result, 64'd0);

    run_op("divu_100_7",   C_DIVU,  64'd100, 64'd7, 64'd14, 66);
    run_op("remu_100_7",   C_REMU,  64'd100, 64'd7, 64'd2, 66);
    run_op("divu_max_3",   C_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 66);
    run_op("remu_max_16",  C_REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 66);
    run_op("divw_m7_2",    C_DIVW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    run_op("remw_m7_2",    C_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("divw_100_m7",  C_DIVW,  64'd100, 64'h0000_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 34);
    run_op("remw_m100_7",  C_REMW,  64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run_op("divuw_min_1",  C_DIVUW, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34);
    run_op("remuw_trunc",  C_REMUW, 64'hABCD_0000_0000_0011, 64'h0000_0001_0000_0005, 64'd2, 34);
    run_op("divu_5_0",     C_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remuw_x_0",    C_REMUW, 64'h0000_0001_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1);
    run_op("divw_ovf",     C_DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf",     C_REMW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 34);
    run_op("divu_3_10",    C_DIVU,  64'd3, 64'd10, 64'd0, early_lat);
    run_op("remu_3_10",    C_REMU,  64'd3, 64'd10, 64'd3, early_lat);

    // flush partway through: no done, busy drops, result held
    done_base = done_cnt;
    prev_res  = result;
    launch(C_DIVU, 64'd1000, 64'd3);
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    repeat (80) @(posedge clk);
    #1 check("flush_nodone", 64'(done_cnt - done_base), 64'd0);
    check("flush_result", result, prev_res);

    // flush and start together in IDLE: nothing accepted
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; ctrl = C_DIVU; dvd = 64'd9; dvs = 64'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);
    check("flush_start_illegal", {63'd0, illegal}, 64'd0);

    // reset mid-operation
    done_base = done_cnt;
    launch(C_DIVU, 64'd777, 64'd5);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_result", result, 64'd0);
    repeat (80) @(posedge clk);
    #1 check("midrst_nodone", 64'(done_cnt - done_base), 64'd0);

    // illegal opcode
    launch(5'b00000, 64'd10, 64'd2);
    check("illegal_pulse", {63'd0, illegal}, 64'd1);
    check("illegal_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("illegal_clear", {63'd0, illegal}, 64'd0);
    check("illegal_busy2", {63'd0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_201979054_div_unit.md
Name: ysyx_201979054_div_unit

Overview:
- Multi-cycle iterative radix-2 restoring divider.
- Executes the divide/remainder ALU control codes produced by the ALU decoder: DIVU, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits beside the single-cycle ALU in the execute stage. The control FSM stalls on o_busy and captures o_result on o_done.

Parameters:
- XLEN, 64, datapath width; W-variants operate on bits [31:0].

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  request; sampled only in IDLE
- i_alu_control  in  5  operation code from the ALU decoder
- i_dividend  in  XLEN  rs1 value
- i_divisor  in  XLEN  rs2 value
- i_flush  in  1  abort in-flight operation
- o_busy  out  1  high from the cycle after accept until o_done
- o_done  out  1  one-cycle result-valid pulse
- o_result  out  XLEN  quotient or remainder
- o_illegal_op  out  1  one-cycle pulse: start with a non-divide code

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset:
  - State returns to IDLE.
  - o_busy, o_done, o_illegal_op = 0; o_result = 0.
  - Reset mid-operation discards all work; no o_done is issued.
- Accepted codes:
  - 10101 DIVU (64-bit unsigned)
  - 10111 REMU
  - 10011 DIVW (32-bit signed)
  - 11001 REMW
  - 10110 DIVUW
  - 11000 REMUW
- Any other code with i_start in IDLE: o_illegal_op = 1 next cycle; state stays IDLE.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On i_start with a legal code, latch operands and op, then go to CALC.
  - W ops use operand[31:0]. Signed ops latch magnitudes plus sign flags.
  - If divisor (width-truncated) is 0, go directly to DONE.
  - If DIVW with dividend = 0x8000_0000 and divisor = 0xFFFF_FFFF, go directly to DONE.
- CALC:
  - N iterations, one per cycle (N = 64 full, N = 32 W).
  - Each iteration shifts the {rem, quo} pair left one bit, trial-subtracts the divisor, and restores on borrow.
  - After the Nth iteration, go to FIX.
- FIX:
  - Apply signs: quotient is negated if the operand signs differ; remainder takes the dividend sign.
  - Select quotient or remainder.
  - W results are sign-extended from bit 31, including DIVUW/REMUW.
- DONE:
  - o_done = 1 for exactly one cycle; o_result is valid that cycle and held until the next accepted start.
  - Return to IDLE.
- Latency from the accept cycle to o_done:
  - Full ops: N + 2 cycles (66).
  - W ops: 34 cycles.
  - Special cases: 1 cycle.
- Divide by zero:
  - Quotient = all ones (XLEN bits).
  - Remainder = dividend (W: sign-extended dividend[31:0]).
- Signed overflow (DIVW -2^31 / -1):
  - Quotient = 0xFFFF_FFFF_8000_0000.
  - Remainder = 0.
- o_busy is high in CALC and FIX; it is low in IDLE and DONE.
- i_start while not IDLE is ignored, with no illegal pulse.
- i_flush:
  - Forces IDLE next cycle from any state; suppresses o_done.
  - Flush and start in the same IDLE cycle: flush wins, nothing is accepted.
  - o_result keeps its previous value.
- Back-to-back: a start is accepted in the cycle after DONE (the IDLE cycle). Minimum issue interval is N + 3 cycles.

Optional Feature:
- Macro DIV_EARLY_OUT_EN, early-out path.
- Defined:
  - In IDLE, if the unsigned dividend magnitude < divisor magnitude (divisor nonzero), go directly to DONE.
  - Quotient = 0; remainder = dividend (W: sign-extended [31:0]).
  - Latency is 1 cycle.
- Undefined: this case takes the full N + 2 cycle path with identical results.

Decomposition:
- Package ysyx_201979054_div_pkg holds:
  - localparams for the six ALU control codes.
  - The FSM state enum typedef (IDLE, CALC, FIX, DONE).
  - A helper function is_div_op(code).
- Sub-module ysyx_201979054_div_step: combinational single restoring iteration.
  - Inputs: partial remainder, divisor, incoming dividend bit.
  - Outputs: next remainder, quotient bit.
- The top level holds the FSM, counter, operand registers and sign fix-up.

Test Plan:
- DIVU 100 / 7: o_done 66 cycles after accept, o_result = 14; REMU same operands gives 2.
- DIVW -7 (0x...FFF9) / 2: o_result = 0xFFFF_FFFF_FFFF_FFFD (-3), latency 34; REMW gives 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVUW 0x8000_0000 / 1: o_result = 0xFFFF_FFFF_8000_0000 (sign-extended).
- DIVU 5 / 0: o_result = 0xFFFF_FFFF_FFFF_FFFF at 1 cycle; REMUW 0x1_8000_0005 / 0 gives 0xFFFF_FFFF_8000_0005.
- DIVW 0x8000_0000 / 0xFFFF_FFFF: 1-cycle o_result = 0xFFFF_FFFF_8000_0000; REMW gives 0.
- Start DIVU, assert i_flush at cycle 10, then i_rst mid-operation on a second run: no o_done, o_busy drops next cycle. Start with code 00000: o_illegal_op pulses once, o_busy stays 0.
